// File: rtl/mul_pkg.sv
// Shared types and helpers for the parametrised sequential multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(w)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_mul_param_abs_conv.sv
// Conditional two's-complement negate; gives operand magnitudes and signs the product.
module abs_conv #(
  parameter int unsigned W = 8
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] mag_c
);

  assign mag_c = neg ? -value : value;

endmodule

// File: rtl/seq_mul_param.sv
// Radix-2 shift-add multiplier with signed/unsigned mode and optional early termination.
module seq_mul_param
  import mul_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int unsigned CW = cnt_width(W);

  state_t         state, state_n;
  logic [2*W-1:0] mcand, mcand_n;
  logic [2*W-1:0] prod, prod_n;
  logic [W-1:0]   mplier, mplier_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           neg, neg_n;
  logic [2*W-1:0] result_n;
  logic           done_n;

  logic [W-1:0]   ma_c, mb_c;
  logic [2*W-1:0] res_c;

  abs_conv #(.W(W)) u_abs_a (
    .neg   (signed_mode & a[W-1]),
    .value (a),
    .mag_c (ma_c)
  );

  abs_conv #(.W(W)) u_abs_b (
    .neg   (signed_mode & b[W-1]),
    .value (b),
    .mag_c (mb_c)
  );

  abs_conv #(.W(2*W)) u_abs_res (
    .neg   (neg),
    .value (prod),
    .mag_c (res_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      prod   <= prod_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
      neg    <= neg_n;
      result <= result_n;
      done   <= done_n;
      busy   <= (state_n != IDLE);
    end
  end

  // Next-state and datapath update; the sign is folded back in only at FIN.
  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    prod_n   = prod;
    mplier_n = mplier;
    cnt_n    = cnt;
    neg_n    = neg;
    result_n = result;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          neg_n    = signed_mode & (a[W-1] ^ b[W-1]);
          mcand_n  = {{W{1'b0}}, ma_c};
          mplier_n = mb_c;
          prod_n   = '0;
          cnt_n    = '0;
          state_n  = ((EARLY_TERM != 0) && (mb_c == '0)) ? FIN : CALC;
        end
      end
      CALC: begin
        if (mplier[0]) prod_n = prod + mcand;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        // Stop when the remaining multiplier bits after this step are all zero.
        if ((cnt == CW'(W - 1)) ||
            ((EARLY_TERM != 0) && (mplier[W-1:1] == '0))) begin
          state_n = FIN;
        end
      end
      FIN: begin
        result_n = res_c;
        done_n   = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench: four multiplier configurations (W=8/16, early-term on/off) checked by a cycle monitor.
module tb_seq_mul_param;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic [3:0]  sm = '0;
  logic [15:0] a_in [4];
  logic [15:0] b_in [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [31:0] res_v [4];

  exp_t        q [4][$];
  int unsigned bs [4];
  int unsigned be [4];
  logic [31:0] last [4];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned WW = (g < 2) ? 8 : 16;
    localparam int unsigned ET = (g % 2 == 0) ? 1 : 0;
    logic          bsy, dn;
    logic [2*WW-1:0] rs;
    seq_mul_param #(.W(WW), .EARLY_TERM(ET)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[g]),
      .signed_mode (sm[g]),
      .a           (a_in[g][WW-1:0]),
      .b           (b_in[g][WW-1:0]),
      .busy        (bsy),
      .done        (dn),
      .result      (rs)
    );
    assign busy_v[g] = bsy;
    assign done_v[g] = dn;
    assign res_v[g]  = 32'(rs);
  end

  function automatic int cfg_w(input int d);
    return (d < 2) ? 8 : 16;
  endfunction

  function automatic bit cfg_et(input int d);
    return (d % 2) == 0;
  endfunction

  function automatic logic [15:0] mask_w(input int w);
    return (w == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic int exp_lat(input int d, input logic [15:0] bv, input logic s);
    int w, n;
    logic [15:0] mb;
    w  = cfg_w(d);
    mb = bv & mask_w(w);
    if (s && mb[w-1]) mb = 16'(-mb) & mask_w(w);
    if (!cfg_et(d)) return w + 1;
    n = 0;
    for (int i = 0; i < w; i++) if (mb[i]) n = i + 1;
    return 1 + n;
  endfunction

  function automatic logic [31:0] ref_prod(input int d, input logic [15:0] av,
                                           input logic [15:0] bv, input logic s);
    int w;
    longint sa, sb, p;
    w  = cfg_w(d);
    sa = longint'(av & mask_w(w));
    sb = longint'(bv & mask_w(w));
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p) & ((w == 16) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", nm, d, act, expv, cyc);
    end
  endtask

  // Monitor: compares every DUT output each cycle against the scoreboard.
  initial begin
    logic r;
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      bs[d] = 0; be[d] = 0; last[d] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      r = rst;
      #1;
      for (int d = 0; d < 4; d++) begin
        if (r) begin
          check("reset_busy", d, 32'(busy_v[d]), 32'd0);
          check("reset_done", d, 32'(done_v[d]), 32'd0);
          check("reset_result", d, res_v[d], 32'd0);
          q[d].delete();
          last[d] = '0;
          bs[d] = 0;
          be[d] = 0;
        end else begin
          check("busy", d, 32'(busy_v[d]), 32'((cyc >= bs[d]) && (cyc < be[d])));
          if (done_v[d]) begin
            if (q[d].size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_done dut%0d: got done=1 expected done=0 at cycle %0d", d, cyc);
            end else begin
              e = q[d].pop_front();
              check("result", d, res_v[d], e.res);
              check("done_cycle", d, 32'(cyc), 32'(e.cyc));
              last[d] = e.res;
            end
          end else begin
            check("result_hold", d, res_v[d], last[d]);
            if (q[d].size() != 0 && q[d][0].cyc <= cyc) begin
              e = q[d].pop_front();
              n_chk++; n_fail++;
              $display("FAIL missing_done dut%0d: got done=0 expected done=1 at cycle %0d", d, cyc);
            end
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic [15:0] av, input logic [15:0] bv,
                       input logic s, input logic [31:0] er);
    exp_t e;
    int l;
    l = exp_lat(d, bv, s);
    a_in[d]  = av;
    b_in[d]  = bv;
    sm[d]    = s;
    start[d] = 1'b1;
    bs[d]    = cyc + 1;
    be[d]    = cyc + 1 + l;
    e.res    = er;
    e.cyc    = be[d];
    q[d].push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0) return;
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle_timeout: got pending ops expected none at cycle %0d", cyc);
    for (int d = 0; d < 4; d++) q[d].delete();
  endtask

  task automatic dir8(input logic [15:0] av, input logic [15:0] bv, input logic s,
                      input logic [31:0] er);
    issue(0, av, bv, s, er);
    issue(1, av, bv, s, er);
    @(negedge clk);
    start = '0;
    wait_idle();
  endtask

  logic [15:0] dt_a [7] = '{16'h0E, 16'hFF, 16'h4D, 16'hFD, 16'h80, 16'h80, 16'h00};
  logic [15:0] dt_b [7] = '{16'h0D, 16'hFF, 16'h00, 16'h05, 16'h80, 16'h01, 16'hFF};
  logic        dt_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] dt_r [7] = '{32'h00B6, 32'hFE01, 32'h0000, 32'hFFF1, 32'h4000, 32'hFF80, 32'h0000};

  logic [15:0] hs_a [6] = '{16'h0E, 16'hFF, 16'hFD, 16'h80, 16'h03, 16'h80};
  logic [15:0] hs_b [6] = '{16'h0D, 16'hFF, 16'h05, 16'h80, 16'h05, 16'h01};
  logic        hs_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] hs_r [6] = '{32'h00B6, 32'hFE01, 32'hFFF1, 32'h4000, 32'h000F, 32'hFF80};

  initial begin
    int idx [2];
    int unsigned nacc [2];
    logic [15:0] av, bv;
    logic s;
    for (int d = 0; d < 4; d++) begin
      a_in[d] = '0; b_in[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) dir8(dt_a[i], dt_b[i], dt_s[i], dt_r[i]);

    // Start held high with junk operands between accepts.
    idx[0] = 0; idx[1] = 0;
    nacc[0] = cyc + 1; nacc[1] = cyc + 1;
    for (int c = 0; c < 200 && (idx[0] < 6 || idx[1] < 6); c++) begin
      for (int d = 0; d < 2; d++) begin
        if (idx[d] < 6 && cyc + 1 == nacc[d]) begin
          issue(d, hs_a[idx[d]], hs_b[idx[d]], hs_s[idx[d]], hs_r[idx[d]]);
          nacc[d] = be[d] + 1;
          idx[d]++;
        end else begin
          a_in[d]  = 16'($urandom);
          b_in[d]  = 16'($urandom);
          sm[d]    = 1'($urandom);
          start[d] = (idx[d] < 6);
        end
      end
      @(negedge clk);
    end
    start = '0;
    wait_idle();

    // Reset three edges after the start edge aborts the operation.
    issue(0, 16'd200, 16'd201, 1'b0, 32'd40200);
    issue(1, 16'd200, 16'd201, 1'b0, 32'd40200);
    @(negedge clk);
    start = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dir8(16'd3, 16'd5, 1'b0, 32'h000F);

    for (int i = 0; i < 1000; i++) begin
      for (int d = 0; d < 4; d++) begin
        av = 16'($urandom) & mask_w(cfg_w(d));
        bv = 16'($urandom) & mask_w(cfg_w(d));
        s  = 1'($urandom_range(0, 1));
        issue(d, av, bv, s, ref_prod(d, av, bv, s));
      end
      @(negedge clk);
      start = '0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
- Parametrised sequential shift-add (radix-2) multiplier; successor to the fixed 4-bit unsigned multiplier.
- Adds: operand width W; runtime signed/unsigned mode; start/busy/done handshake; optional early termination.
- Sits as a shared arithmetic unit behind a simple controller that pulses start and waits for done.

Parameters:
- W, 8, operand width in bits (W >= 2); result is 2W bits.
- EARLY_TERM, 1, 1 = stop iterating once the remaining multiplier bits are zero; 0 = fixed latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- a  in  W  multiplicand; latched with start.
- b  in  W  multiplier; latched with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  registered one-cycle pulse when result updates.
- result  out  2W  product; holds its value until the next done.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, result=0, done=0, busy=0, and all internal registers = 0. Reset mid-operation aborts the operation with no done pulse; it has priority over everything else.
- States: IDLE, CALC, FIN.
- IDLE, on edge with start=1:
  - Latch mode.
  - Magnitudes: ma = |a|, mb = |b| when signed_mode=1, else ma = a, mb = b. The most negative value -2^(W-1) has magnitude 2^(W-1), which fits in W bits unsigned.
  - neg = a[W-1]^b[W-1] when signed_mode=1, else neg = 0.
  - mcand = {W zeros, ma} (2W bits), mplier = mb, prod = 0, cnt = 0.
  - Next state: FIN if EARLY_TERM=1 and mb==0; otherwise CALC.
- IDLE with start=0: stay. A start asserted outside IDLE is ignored and is not queued.
- CALC, each edge performs one iteration:
  - If mplier[0]=1, prod += mcand (2W-bit add, never overflows).
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - Go to FIN if cnt==W-1, or if EARLY_TERM=1 and mplier[W-1:1]==0. Otherwise stay in CALC.
- FIN, one edge: result <= neg ? -prod : prod (2W-bit two's complement); done <= 1; state <= IDLE.
- done is 0 on every other edge.
- Latency, start edge to done-high edge:
  - EARLY_TERM=0: W+1 cycles.
  - EARLY_TERM=1: 1+n cycles, where n = index of the highest set bit of mb, plus 1 (n=0 when mb==0); maximum W+1.
- Back-to-back: the state is IDLE in the cycle where done is high, so start in that cycle is accepted. No dead cycle between operations.
- Operand or mode changes while busy have no effect.
- A zero product with neg=1 yields result=0.
- Unsigned maximum (2^W-1)^2 fits in 2W bits. Signed maximum (-2^(W-1))^2 = 2^(2W-2) is positive and fits.

Decomposition:
- Package mul_pkg holds:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, FIN=2'd2.
  - A width function for the counter: clog2(W).
- One natural sub-module: abs_conv (parameter W). Combinational conditional negate, used for operand magnitudes and for result negation (instantiated at W and 2W).
- The FSM and datapath stay in seq_mul_param.

Test Plan:
- Unsigned path, W=8, EARLY_TERM=1: a=14, b=13, signed_mode=0, start pulse.
  - Required: done exactly 5 cycles after the start edge; result=16'h00B6 (182); busy high for 5 cycles.
- Fixed latency and extremes: EARLY_TERM=0, W=8.
  - a=255, b=255 unsigned -> result=16'hFE01, done at start+9.
  - b=0 -> result=0, also at start+9.
- Signed path: signed_mode=1.
  - a=8'hFD (-3), b=5 -> 16'hFFF1.
  - a=8'h80, b=8'h80 -> 16'h4000.
  - a=8'h80, b=1 -> 16'hFF80.
  - a=0, b=8'hFF -> 16'h0000.
- Handshake: start held high continuously with new operands every cycle.
  - Required: start is ignored while busy; each done carries the product of the operands latched at its start.
  - Required: back-to-back ops have no idle gap (the new op starts in the done cycle).
  - Required: result holds between done pulses.
- Reset mid-operation: rst for 1 cycle at start+3.
  - Required: next cycle busy=0, done=0, result=0, and no done for the aborted op.
  - Required: the next start (a=3, b=5) gives 16'h000F.
- Random self-check: 1000 random a, b, mode at W=8 and W=16, both EARLY_TERM values.
  - Required: result matches the reference model; done width is exactly 1 cycle; latency matches the formula.
